// File: rtl/cam_pkg.sv
// Shared widths, types and the per-cycle operation encoding for the CAM storage stage.
package cam_pkg;
  localparam int CAM_WIDTH      = 32;
  localparam int CAM_ADDR_WIDTH = 5;

  typedef logic [CAM_WIDTH-1:0]      cam_data_t;
  typedef logic [CAM_ADDR_WIDTH-1:0] cam_index_t;

  typedef enum logic [1:0] {
    CAM_NOP,
    CAM_READ,
    CAM_WRITE,
    CAM_SEARCH
  } cam_op_e;
endpackage

// File: rtl/cam_priority_encoder.sv
// Combinational lowest-set-bit encoder used to resolve multiple CAM matches.
module cam_priority_encoder
  import cam_pkg::*;
#(
  parameter int DEPTH = 32,
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic [DEPTH-1:0] match_i,
  output logic             hit_o,
  output logic [IW-1:0]    index_o
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    hit_o   = 1'b0;
    index_o = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (match_i[i]) begin
        hit_o   = 1'b1;
        index_o = IW'(i);
      end
    end
  end

endmodule

// File: rtl/cam_storage.sv
// CAM storage and match stage: one read, write or search per cycle with
// registered results (read > write > search).
module cam_storage
  import cam_pkg::*;
#(
  parameter int WIDTH      = CAM_WIDTH,
  parameter int ADDR_WIDTH = CAM_ADDR_WIDTH,
  localparam int DEPTH     = 2 ** ADDR_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  read_enable_i,
  input  logic [ADDR_WIDTH-1:0] read_index_i,
  input  logic                  write_enable_i,
  input  logic [ADDR_WIDTH-1:0] write_index_i,
  input  logic [WIDTH-1:0]      write_data_i,
  input  logic                  search_enable_i,
  input  logic [WIDTH-1:0]      search_data_i,
  output logic                  read_valid_o,
  output logic [WIDTH-1:0]      read_value_o,
  output logic                  read_entry_valid_o,
  output logic                  search_valid_o,
  output logic                  search_hit_o,
  output logic [ADDR_WIDTH-1:0] search_index_o
);

  logic [WIDTH-1:0]      mem_q [DEPTH];
  logic [DEPTH-1:0]      valid_q;
  logic [DEPTH-1:0]      match;
  logic                  enc_hit;
  logic [ADDR_WIDTH-1:0] enc_index;
  cam_op_e               op;

  logic                  read_valid_q,       read_valid_d;
  logic [WIDTH-1:0]      read_value_q,       read_value_d;
  logic                  read_entry_valid_q, read_entry_valid_d;
  logic                  search_valid_q,     search_valid_d;
  logic                  search_hit_q,       search_hit_d;
  logic [ADDR_WIDTH-1:0] search_index_q,     search_index_d;

  always_comb begin
    op = CAM_NOP;
    if (read_enable_i)        op = CAM_READ;
    else if (write_enable_i)  op = CAM_WRITE;
    else if (search_enable_i) op = CAM_SEARCH;
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      match[i] = valid_q[i] && (mem_q[i] == search_data_i);
    end
  end

  cam_priority_encoder #(.DEPTH(DEPTH)) u_prio_enc (
    .match_i (match),
    .hit_o   (enc_hit),
    .index_o (enc_index)
  );

  always_comb begin
    read_valid_d       = (op == CAM_READ);
    read_value_d       = read_value_q;
    read_entry_valid_d = read_entry_valid_q;
    search_valid_d     = (op == CAM_SEARCH);
    search_hit_d       = search_hit_q;
    search_index_d     = search_index_q;
    if (op == CAM_READ) begin
      // Invalid entries read back as zero so stale data never leaks out.
      read_entry_valid_d = valid_q[read_index_i];
      read_value_d       = valid_q[read_index_i] ? mem_q[read_index_i] : '0;
    end
    if (op == CAM_SEARCH) begin
      search_hit_d   = enc_hit;
      search_index_d = enc_index;
    end
  end

  // Entry data is only observable through valid bits, so it carries no reset.
  always_ff @(posedge clk_i) begin
    if (op == CAM_WRITE) mem_q[write_index_i] <= write_data_i;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      valid_q            <= '0;
      read_valid_q       <= 1'b0;
      read_value_q       <= '0;
      read_entry_valid_q <= 1'b0;
      search_valid_q     <= 1'b0;
      search_hit_q       <= 1'b0;
      search_index_q     <= '0;
    end else begin
      if (op == CAM_WRITE) valid_q[write_index_i] <= 1'b1;
      read_valid_q       <= read_valid_d;
      read_value_q       <= read_value_d;
      read_entry_valid_q <= read_entry_valid_d;
      search_valid_q     <= search_valid_d;
      search_hit_q       <= search_hit_d;
      search_index_q     <= search_index_d;
    end
  end

  assign read_valid_o       = read_valid_q;
  assign read_value_o       = read_value_q;
  assign read_entry_valid_o = read_entry_valid_q;
  assign search_valid_o     = search_valid_q;
  assign search_hit_o       = search_hit_q;
  assign search_index_o     = search_index_q;

endmodule

// File: tb/tb_cam_storage.sv
// Self-checking bench for cam_storage: directed vector table, async reset
// sequence, then randomized traffic against a behavioural model.
module tb_cam_storage;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        read_enable_i;
  logic [4:0]  read_index_i;
  logic        write_enable_i;
  logic [4:0]  write_index_i;
  logic [31:0] write_data_i;
  logic        search_enable_i;
  logic [31:0] search_data_i;
  logic        read_valid_o;
  logic [31:0] read_value_o;
  logic        read_entry_valid_o;
  logic        search_valid_o;
  logic        search_hit_o;
  logic [4:0]  search_index_o;

  cam_storage dut (
    .clk_i              (clk_i),
    .reset_i            (reset_i),
    .read_enable_i      (read_enable_i),
    .read_index_i       (read_index_i),
    .write_enable_i     (write_enable_i),
    .write_index_i      (write_index_i),
    .write_data_i       (write_data_i),
    .search_enable_i    (search_enable_i),
    .search_data_i      (search_data_i),
    .read_valid_o       (read_valid_o),
    .read_value_o       (read_value_o),
    .read_entry_valid_o (read_entry_valid_o),
    .search_valid_o     (search_valid_o),
    .search_hit_o       (search_hit_o),
    .search_index_o     (search_index_o)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model: entry contents plus the result registers it implies.
  logic [31:0] m_mem   [32];
  logic        m_valid [32];
  logic        e_rv, e_rev, e_sv, e_hit;
  logic [31:0] e_rval;
  logic [4:0]  e_idx;

  typedef struct {
    logic        re;
    logic [4:0]  ri;
    logic        we;
    logic [4:0]  wi;
    logic [31:0] wd;
    logic        se;
    logic [31:0] sd;
    logic        rv;
    logic [31:0] rval;
    logic        rev;
    logic        sv;
    logic        hit;
    logic [4:0]  idx;
  } vec_t;

  vec_t tbl[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_outputs(input string tag, input logic rv, input logic [31:0] rval,
                               input logic rev, input logic sv, input logic hit,
                               input logic [4:0] idx);
    chk({tag, ".read_valid"},       32'(read_valid_o),       32'(rv));
    chk({tag, ".read_value"},       read_value_o,            rval);
    chk({tag, ".read_entry_valid"}, 32'(read_entry_valid_o), 32'(rev));
    chk({tag, ".search_valid"},     32'(search_valid_o),     32'(sv));
    chk({tag, ".search_hit"},       32'(search_hit_o),       32'(hit));
    chk({tag, ".search_index"},     32'(search_index_o),     32'(idx));
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_valid[i] = 1'b0;
    e_rv = 1'b0; e_rval = '0; e_rev = 1'b0;
    e_sv = 1'b0; e_hit = 1'b0; e_idx = '0;
  endtask

  // Drive one request, advance one clock, and update the model's expectations.
  task automatic step(input logic re, input logic [4:0] ri, input logic we, input logic [4:0] wi,
                      input logic [31:0] wd, input logic se, input logic [31:0] sd);
    read_enable_i   = re; read_index_i  = ri;
    write_enable_i  = we; write_index_i = wi; write_data_i = wd;
    search_enable_i = se; search_data_i = sd;
    @(posedge clk_i);
    #1;
    e_rv = re;
    e_sv = !re && !we && se;
    if (re) begin
      e_rev  = m_valid[ri];
      e_rval = m_valid[ri] ? m_mem[ri] : 32'h0;
    end else if (we) begin
      m_mem[wi]   = wd;
      m_valid[wi] = 1'b1;
    end else if (se) begin
      e_hit = 1'b0;
      e_idx = '0;
      for (int i = 0; i < 32; i++) begin
        if (m_valid[i] && m_mem[i] == sd) begin
          e_hit = 1'b1;
          e_idx = 5'(i);
          break;
        end
      end
    end
  endtask

  task automatic idle_inputs();
    read_enable_i = 1'b0; read_index_i = '0;
    write_enable_i = 1'b0; write_index_i = '0; write_data_i = '0;
    search_enable_i = 1'b0; search_data_i = '0;
  endtask

  function automatic vec_t mk(input logic re, input logic [4:0] ri, input logic we,
                              input logic [4:0] wi, input logic [31:0] wd, input logic se,
                              input logic [31:0] sd, input logic rv, input logic [31:0] rval,
                              input logic rev, input logic sv, input logic hit,
                              input logic [4:0] idx);
    vec_t v;
    v.re = re; v.ri = ri; v.we = we; v.wi = wi; v.wd = wd; v.se = se; v.sd = sd;
    v.rv = rv; v.rval = rval; v.rev = rev; v.sv = sv; v.hit = hit; v.idx = idx;
    return v;
  endfunction

  logic [31:0] pool [4];

  initial begin
    //            re    ri     we    wi     wd            se    sd              rv    rval          rev   sv    hit   idx
    tbl[0]  = mk(1'b1, 5'd3,  1'b0, 5'd0,  32'h0,        1'b0, 32'h0,        1'b1, 32'h0,        1'b0, 1'b0, 1'b0, 5'd0);
    tbl[1]  = mk(1'b0, 5'd0,  1'b0, 5'd0,  32'h0,        1'b1, 32'h0,        1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 5'd0);
    tbl[2]  = mk(1'b0, 5'd0,  1'b1, 5'd7,  32'hDEADBEEF, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 5'd0);
    tbl[3]  = mk(1'b1, 5'd7,  1'b0, 5'd0,  32'h0,        1'b0, 32'h0,        1'b1, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0, 5'd0);
    tbl[4]  = mk(1'b0, 5'd0,  1'b1, 5'd20, 32'h12345678, 1'b0, 32'h0,        1'b0, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0, 5'd0);
    tbl[5]  = mk(1'b0, 5'd0,  1'b1, 5'd9,  32'h12345678, 1'b0, 32'h0,        1'b0, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0, 5'd0);
    tbl[6]  = mk(1'b0, 5'd0,  1'b0, 5'd0,  32'h0,        1'b1, 32'h12345678, 1'b0, 32'hDEADBEEF, 1'b1, 1'b1, 1'b1, 5'd9);
    tbl[7]  = mk(1'b0, 5'd0,  1'b1, 5'd9,  32'h0,        1'b0, 32'h0,        1'b0, 32'hDEADBEEF, 1'b1, 1'b0, 1'b1, 5'd9);
    tbl[8]  = mk(1'b0, 5'd0,  1'b0, 5'd0,  32'h0,        1'b1, 32'h12345678, 1'b0, 32'hDEADBEEF, 1'b1, 1'b1, 1'b1, 5'd20);
    tbl[9]  = mk(1'b1, 5'd7,  1'b1, 5'd7,  32'h1,        1'b1, 32'h1,        1'b1, 32'hDEADBEEF, 1'b1, 1'b0, 1'b1, 5'd20);
    tbl[10] = mk(1'b1, 5'd7,  1'b0, 5'd0,  32'h0,        1'b0, 32'h0,        1'b1, 32'hDEADBEEF, 1'b1, 1'b0, 1'b1, 5'd20);
    tbl[11] = mk(1'b0, 5'd0,  1'b0, 5'd0,  32'h0,        1'b1, 32'h1,        1'b0, 32'hDEADBEEF, 1'b1, 1'b1, 1'b0, 5'd0);
    tbl[12] = mk(1'b0, 5'd0,  1'b1, 5'd31, 32'hA5A5A5A5, 1'b0, 32'h0,        1'b0, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0, 5'd0);
    tbl[13] = mk(1'b0, 5'd0,  1'b0, 5'd0,  32'h0,        1'b1, 32'hA5A5A5A5, 1'b0, 32'hDEADBEEF, 1'b1, 1'b1, 1'b1, 5'd31);
    tbl[14] = mk(1'b0, 5'd0,  1'b0, 5'd0,  32'h0,        1'b1, 32'h0,        1'b0, 32'hDEADBEEF, 1'b1, 1'b1, 1'b1, 5'd9);

    idle_inputs();
    reset_i = 1'b1;
    model_reset();
    #1;
    check_outputs("reset", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0);
    @(posedge clk_i); @(posedge clk_i);
    #1 reset_i = 1'b0;

    for (int v = 0; v < 15; v++) begin
      step(tbl[v].re, tbl[v].ri, tbl[v].we, tbl[v].wi, tbl[v].wd, tbl[v].se, tbl[v].sd);
      check_outputs($sformatf("vec%0d", v), tbl[v].rv, tbl[v].rval, tbl[v].rev,
                    tbl[v].sv, tbl[v].hit, tbl[v].idx);
    end

    // Async reset landing between edges while a search is presented.
    step(1'b0, 5'd0, 1'b1, 5'd5, 32'hCAFEF00D, 1'b0, 32'h0);
    step(1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b1, 32'hCAFEF00D);
    check_outputs("pre_rst", 1'b0, 32'hDEADBEEF, 1'b1, 1'b1, 1'b1, 5'd5);
    read_enable_i = 1'b0; write_enable_i = 1'b0;
    search_enable_i = 1'b1; search_data_i = 32'hCAFEF00D;
    #2 reset_i = 1'b1;
    #1;
    check_outputs("async_rst", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0);
    model_reset();
    #1 reset_i = 1'b0;
    search_enable_i = 1'b0;
    @(posedge clk_i);
    #1;
    check_outputs("post_rst", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0);
    step(1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b1, 32'hCAFEF00D);
    check_outputs("rst_miss", 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 5'd0);

    // Randomized traffic; a small data pool keeps hits and duplicate matches frequent.
    pool[0] = 32'h00000000; pool[1] = 32'h5A5A0001;
    pool[2] = 32'hFFFFFFFF; pool[3] = 32'h13579BDF;
    for (int c = 0; c < 400; c++) begin
      step(1'($urandom_range(0, 3) == 0), 5'($urandom_range(0, 31)),
           1'($urandom_range(0, 1)),      5'($urandom_range(0, 31)),
           pool[$urandom_range(0, 3)],
           1'($urandom_range(0, 1)),      pool[$urandom_range(0, 3)]);
      check_outputs($sformatf("rnd%0d", c), e_rv, e_rval, e_rev, e_sv, e_hit, e_idx);
    end

    idle_inputs();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
